// File: rtl/snake_pkg.sv
// snake_pkg: types and helpers shared by the snake game engine.
//   dir_t        movement direction (encoding matches the dir_req port)
//   state_t      game state (encoding matches the game_state port)
//   QRY_*        codes returned on the renderer query port
//   dir_opposite reverse of a direction, used to drop U-turn requests
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    localparam logic [1:0] QRY_EMPTY = 2'd0;
    localparam logic [1:0] QRY_HEAD  = 2'd1;
    localparam logic [1:0] QRY_BODY  = 2'd2;

    function automatic dir_t dir_opposite(input dir_t d);
        dir_t r;
        unique case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_body_fifo.sv
// snake_body_fifo: circular buffer of body cells, oldest entry = tail.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   clr_i                empty the buffer (pointers and count to zero)
//   push_i, push_x_i/y_i append a new head cell
//   pop_i                drop the tail cell
//   tail_x_o, tail_y_o   current tail cell (valid when count_o > 0)
//   count_o              number of stored cells
// Push and pop in the same cycle are allowed, also when full: the tail is
// read before the write lands, so a full buffer can shift by one cell.
module snake_body_fifo
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int XW      = 6,
    parameter int YW      = 5,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [XW-1:0] push_x_i,
    input  logic [YW-1:0] push_y_i,
    input  logic          pop_i,
    output logic [XW-1:0] tail_x_o,
    output logic [YW-1:0] tail_y_o,
    output logic [LW-1:0] count_o
);

    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [XW+YW-1:0] mem_q [MAX_LEN];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= {push_x_i, push_y_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign tail_x_o = mem_q[rd_ptr_q][XW+YW-1:YW];
    assign tail_y_o = mem_q[rd_ptr_q][YW-1:0];
    assign count_o  = count_q;

endmodule

// File: rtl/snake_core.sv
// snake_core: greedy-snake game engine. Holds the body (circular buffer
// plus one occupancy bit per grid cell), arbitrates direction requests,
// moves/grows the snake on each step and detects wall/self collisions.
// Ports:
//   CLK_50M, RST          clock, synchronous active-high reset
//   start                 begin a game from IDLE or DEAD
//   step                  movement tick
//   dir_valid, dir_req    direction request (0 up, 1 down, 2 left, 3 right)
//   apple_x/y             apple cell, sampled on step cycles
//   query_x/y, query_hit  renderer lookup, 1-cycle registered result
//   head_x/y, length      head cell and body length
//   game_state            0 IDLE, 1 LOAD, 2 RUN, 3 DEAD
//   ate, hit_wall/body    one-cycle event pulses
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | clear body, then lay INIT_LEN segments left-to-right
// RUN   | moving on each step
// DEAD  | collided; body frozen for display, waiting for start
module snake_core
    import snake_pkg::*;
#(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 3,
    parameter int WRAP     = 0,
    parameter int XW       = $clog2(GRID_W),
    parameter int YW       = $clog2(GRID_H),
    parameter int LW       = $clog2(MAX_LEN + 1)
) (
    input  logic          CLK_50M,
    input  logic          RST,
    input  logic          start,
    input  logic          step,
    input  logic          dir_valid,
    input  logic [1:0]    dir_req,
    input  logic [XW-1:0] apple_x,
    input  logic [YW-1:0] apple_y,
    input  logic [XW-1:0] query_x,
    input  logic [YW-1:0] query_y,
    output logic [1:0]    query_hit,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic [1:0]    game_state,
    output logic          ate,
    output logic          hit_wall,
    output logic          hit_body
);

    localparam int CELLS = GRID_W * GRID_H;
    localparam int CW    = $clog2(CELLS);
    localparam int CX    = GRID_W / 2;
    localparam int CY    = GRID_H / 2;

    state_t         state_q, state_d;
    logic [LW-1:0]  load_cnt_q, load_cnt_d;
    logic [XW-1:0]  head_x_q, head_x_d;
    logic [YW-1:0]  head_y_q, head_y_d;
    dir_t           dir_q, dir_d;
    dir_t           pend_q, pend_d;
    logic [CELLS-1:0] bitmap_q, bitmap_d;
    logic           ate_q, ate_d;
    logic           hit_wall_q, hit_wall_d;
    logic           hit_body_q, hit_body_d;
    logic [1:0]     query_q, query_d;

    logic           fifo_clr, fifo_push, fifo_pop;
    logic [XW-1:0]  push_x, tail_x;
    logic [YW-1:0]  push_y, tail_y;
    logic [LW-1:0]  fifo_count;

    logic [XW-1:0]  nx;
    logic [YW-1:0]  ny;
    logic           off_grid;
    logic           eat, grow, at_tail;
    dir_t           dir_ref;

    function automatic logic [CW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return CW'(int'(y) * GRID_W + int'(x));
    endfunction

    snake_body_fifo #(
        .MAX_LEN (MAX_LEN),
        .XW      (XW),
        .YW      (YW),
        .LW      (LW)
    ) u_body (
        .clk_i    (CLK_50M),
        .rst_i    (RST),
        .clr_i    (fifo_clr),
        .push_i   (fifo_push),
        .push_x_i (push_x),
        .push_y_i (push_y),
        .pop_i    (fifo_pop),
        .tail_x_o (tail_x),
        .tail_y_o (tail_y),
        .count_o  (fifo_count)
    );

    // Candidate head: the pending direction is the one committed by this step.
    // The wrapped coordinate is always produced; off_grid decides its use.
    always_comb begin
        nx       = head_x_q;
        ny       = head_y_q;
        off_grid = 1'b0;
        unique case (pend_q)
            DIR_UP: begin
                if (head_y_q == '0) begin
                    off_grid = 1'b1;
                    ny = YW'(GRID_H - 1);
                end else begin
                    ny = head_y_q - 1'b1;
                end
            end
            DIR_DOWN: begin
                if (head_y_q == YW'(GRID_H - 1)) begin
                    off_grid = 1'b1;
                    ny = '0;
                end else begin
                    ny = head_y_q + 1'b1;
                end
            end
            DIR_LEFT: begin
                if (head_x_q == '0) begin
                    off_grid = 1'b1;
                    nx = XW'(GRID_W - 1);
                end else begin
                    nx = head_x_q - 1'b1;
                end
            end
            DIR_RIGHT: begin
                if (head_x_q == XW'(GRID_W - 1)) begin
                    off_grid = 1'b1;
                    nx = '0;
                end else begin
                    nx = head_x_q + 1'b1;
                end
            end
        endcase
    end

    assign eat     = (nx == apple_x) && (ny == apple_y);
    assign grow    = eat && (fifo_count < LW'(MAX_LEN));
    assign at_tail = (nx == tail_x) && (ny == tail_y);

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        bitmap_d   = bitmap_q;
        ate_d      = 1'b0;
        hit_wall_d = 1'b0;
        hit_body_d = 1'b0;
        fifo_clr   = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        push_x     = head_x_q;
        push_y     = head_y_q;

        // A request arriving with a step is judged against the direction
        // that step commits, so it cannot reverse the new heading.
        dir_ref = (state_q == ST_RUN && step) ? pend_q : dir_q;
        if (dir_valid && dir_t'(dir_req) != dir_opposite(dir_ref)) begin
            pend_d = dir_t'(dir_req);
        end
        if (state_q == ST_RUN && step) begin
            dir_d = pend_q;
        end

        unique case (state_q)
            ST_IDLE, ST_DEAD: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = LW'(INIT_LEN);
                end
            end
            ST_LOAD: begin
                // Down-counter: INIT_LEN is the clear cycle, then each count
                // lays the segment CX-count so the last one lands on centre.
                if (load_cnt_q == LW'(INIT_LEN)) begin
                    bitmap_d = '0;
                    fifo_clr = 1'b1;
                    dir_d    = DIR_RIGHT;
                    pend_d   = DIR_RIGHT;
                end else begin
                    push_x    = XW'(CX - int'(load_cnt_q));
                    push_y    = YW'(CY);
                    fifo_push = 1'b1;
                    head_x_d  = push_x;
                    head_y_d  = push_y;
                    bitmap_d[cell_idx(push_x, push_y)] = 1'b1;
                end
                if (load_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    load_cnt_d = load_cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (step) begin
                    if (off_grid && (WRAP == 0)) begin
                        state_d    = ST_DEAD;
                        hit_wall_d = 1'b1;
                    end else if (bitmap_q[cell_idx(nx, ny)] && !(at_tail && !grow)) begin
                        state_d    = ST_DEAD;
                        hit_body_d = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                        push_x    = nx;
                        push_y    = ny;
                        head_x_d  = nx;
                        head_y_d  = ny;
                        ate_d     = eat;
                        if (!grow) begin
                            fifo_pop = 1'b1;
                            bitmap_d[cell_idx(tail_x, tail_y)] = 1'b0;
                        end
                        // Set after the tail clear so a tail-chasing head stays marked.
                        bitmap_d[cell_idx(nx, ny)] = 1'b1;
                    end
                end
            end
        endcase
    end

    // Head is reported only where a segment exists, so the idle head
    // position does not show on screen.
    always_comb begin
        query_d = QRY_EMPTY;
        if (int'(query_x) < GRID_W && int'(query_y) < GRID_H &&
            bitmap_q[cell_idx(query_x, query_y)]) begin
            query_d = (query_x == head_x_q && query_y == head_y_q) ? QRY_HEAD : QRY_BODY;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            load_cnt_q <= '0;
            head_x_q   <= XW'(CX);
            head_y_q   <= YW'(CY);
            dir_q      <= DIR_RIGHT;
            pend_q     <= DIR_RIGHT;
            bitmap_q   <= '0;
            ate_q      <= 1'b0;
            hit_wall_q <= 1'b0;
            hit_body_q <= 1'b0;
            query_q    <= QRY_EMPTY;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            bitmap_q   <= bitmap_d;
            ate_q      <= ate_d;
            hit_wall_q <= hit_wall_d;
            hit_body_q <= hit_body_d;
            query_q    <= query_d;
        end
    end

    assign query_hit  = query_q;
    assign head_x     = head_x_q;
    assign head_y     = head_y_q;
    assign length     = fifo_count;
    assign game_state = state_q;
    assign ate        = ate_q;
    assign hit_wall   = hit_wall_q;
    assign hit_body   = hit_body_q;

endmodule

// File: tb/tb_snake_core.sv
// Bench for snake_core: instance 0 uses walls and MAX_LEN 64, instance 1
// wraps with MAX_LEN 4. Both share stimulus; a queue-based game model
// predicts every output of both each cycle.
module tb_snake_core;

    localparam int GW = 40;
    localparam int GH = 30;
    localparam int IL = 3;

    logic       clk = 1'b0;
    logic       rst, start, step, dir_valid;
    logic [1:0] dir_req;
    logic [5:0] apple_x, query_x;
    logic [4:0] apple_y, query_y;

    logic [1:0] qh [2];
    logic [5:0] hx [2];
    logic [4:0] hy [2];
    logic [1:0] gs [2];
    logic       at [2], hw [2], hb [2];
    logic [6:0] len0;
    logic [2:0] len1;

    always #5 clk = ~clk;

    snake_core dut0 (
        .CLK_50M(clk), .RST(rst), .start(start), .step(step),
        .dir_valid(dir_valid), .dir_req(dir_req),
        .apple_x(apple_x), .apple_y(apple_y), .query_x(query_x), .query_y(query_y),
        .query_hit(qh[0]), .head_x(hx[0]), .head_y(hy[0]), .length(len0),
        .game_state(gs[0]), .ate(at[0]), .hit_wall(hw[0]), .hit_body(hb[0])
    );

    snake_core #(.WRAP(1), .MAX_LEN(4)) dut1 (
        .CLK_50M(clk), .RST(rst), .start(start), .step(step),
        .dir_valid(dir_valid), .dir_req(dir_req),
        .apple_x(apple_x), .apple_y(apple_y), .query_x(query_x), .query_y(query_y),
        .query_hit(qh[1]), .head_x(hx[1]), .head_y(hy[1]), .length(len1),
        .game_state(gs[1]), .ate(at[1]), .hit_wall(hw[1]), .hit_body(hb[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // ---------------- model ----------------
    int ML [2] = '{64, 4};
    int WR [2] = '{0, 1};
    int m_state [2], m_hx [2], m_hy [2], m_dir [2], m_pend [2], m_ld [2];
    int m_ate [2], m_hw [2], m_hb [2], m_q [2];
    int body0 [$];
    int body1 [$];

    function automatic int cell_code(int x, int y);
        return x * 64 + y;
    endfunction

    function automatic int b_size(int k);
        return (k == 0) ? body0.size() : body1.size();
    endfunction

    function automatic void b_clear(int k);
        if (k == 0) body0.delete(); else body1.delete();
    endfunction

    function automatic void b_push(int k, int c);
        if (k == 0) body0.push_back(c); else body1.push_back(c);
    endfunction

    function automatic void b_pop(int k);
        int d;
        if (k == 0) d = body0.pop_front(); else d = body1.pop_front();
    endfunction

    function automatic int b_find(int k, int c);
        for (int i = 0; i < b_size(k); i++) begin
            if (((k == 0) ? body0[i] : body1[i]) == c) return i;
        end
        return -1;
    endfunction

    function automatic int opp(int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic void model_edge(int k);
        int  nx, ny, c, idx, newp, dref;
        bit  eat, grow, stepping;
        if (rst) begin
            m_state[k] = 0; m_hx[k] = GW / 2; m_hy[k] = GH / 2;
            m_dir[k] = 3; m_pend[k] = 3; m_ld[k] = 0;
            m_ate[k] = 0; m_hw[k] = 0; m_hb[k] = 0; m_q[k] = 0;
            b_clear(k);
            return;
        end
        m_q[k] = 0;
        if (int'(query_x) < GW && int'(query_y) < GH &&
            b_find(k, cell_code(int'(query_x), int'(query_y))) >= 0)
            m_q[k] = (int'(query_x) == m_hx[k] && int'(query_y) == m_hy[k]) ? 1 : 2;
        m_ate[k] = 0; m_hw[k] = 0; m_hb[k] = 0;
        stepping = (m_state[k] == 2) && step;
        dref = stepping ? m_pend[k] : m_dir[k];
        newp = m_pend[k];
        if (dir_valid && int'(dir_req) != opp(dref)) newp = int'(dir_req);
        if (stepping) m_dir[k] = m_pend[k];
        case (m_state[k])
            0, 3: if (start) begin m_state[k] = 1; m_ld[k] = 0; end
            1: begin
                if (m_ld[k] == 0) begin
                    b_clear(k); m_dir[k] = 3; newp = 3;
                end else begin
                    m_hx[k] = GW / 2 - IL + m_ld[k];
                    m_hy[k] = GH / 2;
                    b_push(k, cell_code(m_hx[k], m_hy[k]));
                end
                if (m_ld[k] == IL) m_state[k] = 2; else m_ld[k]++;
            end
            2: if (step) begin
                nx = m_hx[k]; ny = m_hy[k];
                case (m_pend[k])
                    0: ny--;
                    1: ny++;
                    2: nx--;
                    default: nx++;
                endcase
                if (WR[k] == 0 && (nx < 0 || nx >= GW || ny < 0 || ny >= GH)) begin
                    m_state[k] = 3; m_hw[k] = 1;
                end else begin
                    nx = (nx + GW) % GW; ny = (ny + GH) % GH;
                    c = cell_code(nx, ny);
                    eat  = (nx == int'(apple_x)) && (ny == int'(apple_y));
                    grow = eat && (b_size(k) < ML[k]);
                    idx  = b_find(k, c);
                    if (idx >= 0 && !(idx == 0 && !grow)) begin
                        m_state[k] = 3; m_hb[k] = 1;
                    end else begin
                        b_push(k, c);
                        m_hx[k] = nx; m_hy[k] = ny;
                        m_ate[k] = int'(eat);
                        if (!grow) b_pop(k);
                    end
                end
            end
            default: ;
        endcase
        m_pend[k] = newp;
    endfunction

    always @(posedge clk) begin
        model_edge(0);
        model_edge(1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("dut%0d.game_state", k), int'(gs[k]), m_state[k]);
                chk($sformatf("dut%0d.head_x", k), int'(hx[k]), m_hx[k]);
                chk($sformatf("dut%0d.head_y", k), int'(hy[k]), m_hy[k]);
                chk($sformatf("dut%0d.length", k), (k == 0) ? int'(len0) : int'(len1), b_size(k));
                chk($sformatf("dut%0d.ate", k), int'(at[k]), m_ate[k]);
                chk($sformatf("dut%0d.hit_wall", k), int'(hw[k]), m_hw[k]);
                chk($sformatf("dut%0d.hit_body", k), int'(hb[k]), m_hb[k]);
                chk($sformatf("dut%0d.query_hit", k), int'(qh[k]), m_q[k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_step();
        step = 1'b1; adv(1); step = 1'b0;
    endtask

    task automatic do_dir(input int d);
        dir_valid = 1'b1; dir_req = 2'(d); adv(1); dir_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; step = 1'b0; dir_valid = 1'b0; dir_req = 2'd0;
        apple_x = 6'd0; apple_y = 5'd0; query_x = 6'd0; query_y = 5'd0;
        adv(1);
        chk_en = 1'b1;
        adv(2);
        @(negedge clk);
        chk("lit_reset_state", int'(gs[0]), 0);
        chk("lit_reset_len", int'(len0), 0);
        chk("lit_reset_hx", int'(hx[0]), 20);
        chk("lit_reset_hy", int'(hy[0]), 15);
        rst = 1'b0;

        // start and LOAD sequence
        start = 1'b1; adv(1); start = 1'b0;
        adv(3);
        @(negedge clk);
        chk("lit_load_state", int'(gs[0]), 1);
        adv(1);
        @(negedge clk);
        chk("lit_run_state", int'(gs[0]), 2);
        chk("lit_run_hx", int'(hx[0]), 20);
        chk("lit_run_len", int'(len0), 3);
        query_x = 6'd18; query_y = 5'd15; adv(1);
        @(negedge clk); chk("lit_query_body", int'(qh[0]), 2);
        query_x = 6'd20; adv(1);
        @(negedge clk); chk("lit_query_head", int'(qh[0]), 1);
        query_x = 6'd17; adv(1);
        @(negedge clk); chk("lit_query_empty", int'(qh[0]), 0);

        // eat one apple
        apple_x = 6'd21; apple_y = 5'd15;
        do_step();
        apple_x = 6'd0; apple_y = 5'd0;
        @(negedge clk);
        chk("lit_eat_hx", int'(hx[0]), 21);
        chk("lit_eat_len", int'(len0), 4);
        chk("lit_eat_ate", int'(at[0]), 1);
        chk("lit_eat_len1", int'(len1), 4);
        adv(1);
        @(negedge clk);
        chk("lit_eat_ate_drop", int'(at[0]), 0);

        // reverse request is dropped
        do_dir(2);
        do_step();
        @(negedge clk);
        chk("lit_rev_hx", int'(hx[0]), 22);
        chk("lit_rev_hy", int'(hy[0]), 15);

        // run to the wall; wrap instance continues
        step = 1'b1;
        adv(17);
        @(negedge clk);
        chk("lit_edge_hx", int'(hx[0]), 39);
        chk("lit_edge_alive", int'(gs[0]), 2);
        adv(1);
        step = 1'b0;
        @(negedge clk);
        chk("lit_wall_pulse", int'(hw[0]), 1);
        chk("lit_wall_dead", int'(gs[0]), 3);
        chk("lit_wall_hx", int'(hx[0]), 39);
        chk("lit_wrap_hx", int'(hx[1]), 0);
        chk("lit_wrap_alive", int'(gs[1]), 2);
        chk("lit_wrap_nowall", int'(hw[1]), 0);

        // saturating growth on the MAX_LEN=4 instance
        apple_x = 6'd1; apple_y = 5'd15;
        do_step();
        @(negedge clk);
        chk("lit_sat1_ate", int'(at[1]), 1);
        chk("lit_sat1_len", int'(len1), 4);
        apple_x = 6'd2;
        do_step();
        @(negedge clk);
        chk("lit_sat2_ate", int'(at[1]), 1);
        chk("lit_sat2_len", int'(len1), 4);
        chk("lit_dead_hold", int'(hx[0]), 39);

        // reset in the middle of LOAD
        rst = 1'b1; adv(1); rst = 1'b0;
        start = 1'b1; adv(1); start = 1'b0;
        adv(2);
        rst = 1'b1; adv(1); rst = 1'b0;
        @(negedge clk);
        chk("lit_midload_state", int'(gs[0]), 0);
        chk("lit_midload_len", int'(len0), 0);

        // grow to 5 (instance 1 saturates at 4), then turn back into the body
        start = 1'b1; adv(1); start = 1'b0;
        adv(4);
        apple_x = 6'd21; apple_y = 5'd15; do_step();
        apple_x = 6'd22; do_step();
        apple_x = 6'd0; apple_y = 5'd0;
        @(negedge clk);
        chk("lit_len5", int'(len0), 5);
        do_dir(0); do_step();
        do_dir(2); do_step();
        do_dir(1); do_step();
        @(negedge clk);
        chk("lit_body_pulse", int'(hb[0]), 1);
        chk("lit_body_dead", int'(gs[0]), 3);
        chk("lit_tail_alive", int'(gs[1]), 2);
        chk("lit_tail_hx", int'(hx[1]), 21);
        do_dir(3); do_step();
        do_dir(0); do_step();
        @(negedge clk);
        chk("lit_loop_alive", int'(gs[1]), 2);
        chk("lit_loop_hy", int'(hy[1]), 14);

        // randomized play
        rst = 1'b1; adv(1); rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 499) == 0);
            start     = ($urandom_range(0, 19) == 0);
            step      = ($urandom_range(0, 2) == 0);
            dir_valid = ($urandom_range(0, 2) == 0);
            dir_req   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                apple_x = 6'(m_hx[i % 2] + $urandom_range(0, 2) - 1);
                apple_y = 5'(m_hy[i % 2] + $urandom_range(0, 2) - 1);
            end else begin
                apple_x = 6'($urandom_range(0, GW - 1));
                apple_y = 5'($urandom_range(0, GH - 1));
            end
            if ($urandom_range(0, 1) == 0) begin
                query_x = 6'(m_hx[i % 2] + $urandom_range(0, 4) - 2);
                query_y = 5'(m_hy[i % 2] + $urandom_range(0, 4) - 2);
            end else begin
                query_x = 6'($urandom_range(0, 63));
                query_y = 5'($urandom_range(0, 31));
            end
            adv(1);
        end
        rst = 1'b0; start = 1'b0; step = 1'b0; dir_valid = 1'b0;
        adv(2);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_core.md
# snake_core

Parametrised game engine for the greedy-snake design. Owns snake body state (circular coordinate buffer plus occupancy bitmap), direction arbitration, growth, wall/self collision and the start/restart sequence. Sits between the key-press decoders, apple generator and VGA renderer. Generalises grid size, maximum length and edge mode (wall or wrap-around), and adds a pixel-independent cell query port for the renderer.

## Interface
- GRID_W, 40: grid columns
- GRID_H, 30: grid rows
- MAX_LEN, 64: maximum body length, including head
- INIT_LEN, 3: length after start; 2 ≤ INIT_LEN ≤ MAX_LEN, INIT_LEN ≤ GRID_W/2
- WRAP, 0: 0 = edges are walls; 1 = edges wrap around
- XW/YW/LW: derived, $clog2(GRID_W), $clog2(GRID_H), $clog2(MAX_LEN+1)

Ports:
- CLK_50M  in  1  clock
- RST  in  1  reset, synchronous, active-high
- start  in  1  pulse; begins a game from IDLE or DEAD
- step  in  1  movement tick pulse
- dir_valid  in  1  direction request strobe
- dir_req  in  2  0 = up, 1 = down, 2 = left, 3 = right
- apple_x / apple_y  in  XW/YW  current apple cell
- query_x / query_y  in  XW/YW  renderer cell lookup
- query_hit  out  2  0 = empty, 1 = head, 2 = body
- head_x / head_y  out  XW/YW  head cell
- length  out  LW  current length
- game_state  out  2  0 = IDLE, 1 = LOAD, 2 = RUN, 3 = DEAD
- ate  out  1  one-cycle pulse when head enters apple cell
- hit_wall / hit_body  out  1  one-cycle death-cause pulses

## Operation
- States:
  - IDLE -(start)-> LOAD
  - LOAD -(INIT_LEN+1 cycles)-> RUN
  - RUN -(collision)-> DEAD
  - DEAD -(start)-> LOAD
  - start in LOAD/RUN is ignored.
- LOAD sequence:
  - Cycle 0: clear bitmap; buffer pointers reset; dir = right.
  - Cycles 1..INIT_LEN: write segment k at (GRID_W/2-INIT_LEN+k, GRID_H/2); length increments each cycle.
  - Final head is at (GRID_W/2, GRID_H/2).
- Direction handling:
  - dir_valid latches dir_req into pending unless it is the reverse of the committed dir. Reverse requests are dropped.
  - The last accepted request before a step wins.
  - pending is committed at the step.
- step in RUN computes next head = head + committed dir.
  - WRAP=0 and next head is off-grid: DEAD, hit_wall pulse; body unchanged.
  - Bitmap set at next head: DEAD, hit_body pulse. Exception: next head == tail and not growing, which is legal (tail vacates).
  - Otherwise: push next head, set its bit.
    - If next head == apple and length < MAX_LEN: keep tail (length+1); pulse ate.
    - If next head == apple and length == MAX_LEN: pulse ate, length saturates, tail pops.
    - Otherwise: clear tail bit, pop tail.
- WRAP=1 arithmetic: x = GRID_W-1 +1 → 0, 0 -1 → GRID_W-1; y likewise with GRID_H. No hit_wall.
- step outside RUN is ignored. In DEAD, head, body and length hold for display.

## Timing
- Reset values:
  - game_state IDLE
  - head (GRID_W/2, GRID_H/2)
  - length 0
  - committed and pending dir = right
  - ate / hit_* / query_hit 0
  - bitmap all clear
- RST mid-LOAD or mid-RUN → IDLE on the next edge.
- step at edge N → head, length, game_state and pulses valid after edge N+1. step spacing is ≥ 1 cycle; back-to-back steps are legal.
- Simultaneous step + dir_valid: the step uses the previously latched pending; the new request applies to the following step.
- query_hit latency: 1 cycle, registered. Reflects the bitmap/head as of the query cycle.
- Apple inputs are sampled on the step cycle only.

## Structure
- snake_pkg:
  - dir_t enum (UP, DOWN, LEFT, RIGHT)
  - state_t enum (IDLE, LOAD, RUN, DEAD)
  - query codes
  - opposite-direction function
- Sub-module snake_body_fifo: MAX_LEN-deep circular buffer of {x,y}.
  - Ports: push, pop, tail output, count.
  - Pointer wrap at MAX_LEN.
- The bitmap (GRID_W*GRID_H flops) and collision logic live in snake_core.

## Test plan
- Reset, start, 4 idle cycles: game_state = RUN at cycle 5 (INIT_LEN+1 after LOAD entry); head (20,15); length 3; query (18,15) → 2, (20,15) → 1, (17,15) → 0.
- RUN dir right, apple at (21,15), one step: head (21,15), length 4, ate high exactly one cycle.
- Reverse request: dir_req = left while moving right, then step: head (21,15)→(22,15); no direction change.
- WRAP=0, 19 steps right from (20,15): hit_wall on step 20; game_state DEAD; head stays (39,15). WRAP=1: same stimulus gives head (0,15), game alive.
- Length 5 in a tight loop (up, left, down, right into own body): hit_body pulse, DEAD. Separate case, length 4 square loop chasing its tail: tail-cell entry legal, no death.
- MAX_LEN=4 instance, eat twice at length 4: length stays 4, ate pulses both times. RST asserted mid-LOAD → IDLE, length 0 next cycle.
